// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, memory size encodings and FSM states shared by the LSU
package load_store_unit_pkg;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
    localparam logic [1:0] SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd3;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/load_store_unit_decode.sv
// lsu_decode: funct3/address decode into memory controls plus legality, alignment and range fault
module lsu_decode
    import load_store_unit_pkg::*;
#(
    parameter int MEM_BYTES = 21
) (
    input  logic [2:0]  funct3,
    input  logic        store,
    input  logic [31:0] addr,
    output logic [1:0]  size,
    output logic        sign_extend,
    output logic        fault
);
    logic [2:0] nbytes;
    logic       legal;
    logic       misaligned;
    logic       out_of_range;
    // Range check is done in 33 bits so addresses near 2^32 cannot wrap back into range
    always_comb begin
        size         = funct3[1:0] == 2'b00 ? SZ_BYTE : funct3[1:0] == 2'b01 ? SZ_HALF : SZ_WORD;
        nbytes       = size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
        sign_extend  = !funct3[2];
        legal        = funct3 inside {LB, LH, LW} || (!store && funct3 inside {LBU, LHU});
        misaligned   = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
        out_of_range = {1'b0, addr} + 33'(nbytes) > 33'(MEM_BYTES);
        fault        = !legal || misaligned || out_of_range;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-outstanding request sequencer between the memory stage and big-endian data memory
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_BYTES = 21
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        mem_sign_extend,
    input  logic [31:0] mem_data_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_fault
);
    state_t     state, next_state;
    logic       store_q;
    logic [4:0] rd_q;
    logic [1:0] dec_size;
    logic       dec_sign_extend;
    logic       dec_fault;

    lsu_decode #(.MEM_BYTES(MEM_BYTES)) u_decode (
        .funct3      (req_funct3),
        .store       (req_store),
        .addr        (req_addr),
        .size        (dec_size),
        .sign_extend (dec_sign_extend),
        .fault       (dec_fault)
    );

    // State register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : next_state;
    end

    // Next state and handshake/write strobes; faults skip ACCESS entirely
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = req_valid ? (dec_fault ? RESP : ACCESS) : IDLE;
            ACCESS:  next_state = RESP;
            RESP:    next_state = resp_ready ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
        req_ready  = state == IDLE && !reset;
        resp_valid = state == RESP;
        mem_we     = state == ACCESS && store_q;
    end

    // Latch the request on acceptance and capture load data at the end of ACCESS
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr        <= '0;
            mem_data_in     <= '0;
            mem_size        <= SZ_BYTE;
            mem_sign_extend <= 1'b0;
            store_q         <= 1'b0;
            rd_q            <= '0;
            resp_data       <= '0;
            resp_rd         <= '0;
            resp_fault      <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            mem_addr        <= req_addr;
            mem_data_in     <= req_wdata;
            mem_size        <= dec_size;
            mem_sign_extend <= dec_sign_extend;
            store_q         <= req_store;
            rd_q            <= req_rd;
            resp_data       <= '0;
            resp_rd         <= '0;
            resp_fault      <= dec_fault;
        end else if (state == ACCESS) begin
            resp_data <= store_q ? '0 : mem_data_out;
            resp_rd   <= store_q ? '0 : rd_q;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-array reference model and a big-endian memory
module tb_load_store_unit;
    import load_store_unit_pkg::*;
    localparam int MB = 21;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
    } resp_t;

    logic        clock = 0, reset = 1, req_valid = 0, req_store = 0, resp_ready = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [4:0]  req_rd = 0;
    logic        req_ready, mem_we, mem_sign_extend, resp_valid, resp_fault;
    logic [31:0] mem_addr, mem_data_in, resp_data;
    logic [31:0] mem_data_out = 0;
    logic [1:0]  mem_size;
    logic [4:0]  resp_rd;

    int    checks = 0, failures = 0, cyc = 0, we_cycles = 0, exp_we = 0;
    bit    rnd = 0;
    resp_t exp_q[$];
    int    hs_cyc[$];
    logic [7:0] mem[MB];
    logic [7:0] ref_mem[MB];

    load_store_unit #(.MEM_BYTES(MB)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_size(mem_size),
        .mem_sign_extend(mem_sign_extend), .mem_data_out(mem_data_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_fault(resp_fault)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Big-endian data memory: write at negedge, then refresh read data for the current address
    always @(negedge clock) begin
        int nb;
        logic [31:0] w;
        longint unsigned idx;
        nb = mem_size == 2'd0 ? 1 : mem_size == 2'd1 ? 2 : 4;
        if (mem_we)
            for (int i = 0; i < nb; i++) begin
                idx = {32'h0, mem_addr} + longint'(i);
                if (idx < MB) mem[int'(idx)] = mem_data_in[8*(nb-1-i) +: 8];
            end
        w = 0;
        for (int i = 0; i < 4; i++) begin
            idx = {32'h0, mem_addr} + longint'(i);
            w = {w[23:0], idx < MB ? mem[int'(idx)] : 8'h00};
        end
        if (nb == 1) mem_data_out = mem_sign_extend ? {{24{w[31]}}, w[31:24]} : {24'h0, w[31:24]};
        else if (nb == 2) mem_data_out = mem_sign_extend ? {{16{w[31]}}, w[31:16]} : {16'h0, w[31:16]};
        else mem_data_out = w;
    end

    // Reference: RV32I load/store semantics over a plain byte array
    function automatic resp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [4:0] rd);
        resp_t r;
        int n;
        longint unsigned base;
        longint v;
        r = '0;
        r.fault = 1;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = {32'h0, a};
        v = 0;
        if (f3 == 3'd3 || f3 >= 3'd6 || (st && f3 >= 3'd4) || base % longint'(n) != 0 || base + longint'(n) > MB)
            return r;
        r.fault = 0;
        if (st) begin
            for (int i = 0; i < n; i++) ref_mem[int'(base) + i] = 8'(wd >> (8 * (n - 1 - i)));
            exp_we++;
            return r;
        end
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(base) + i]);
        if (f3 < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        r.data = 32'(v);
        r.rd = rd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every response handshake
    always @(negedge clock) begin
        resp_t e;
        if (mem_we) we_cycles++;
        if (!reset && resp_valid && resp_ready) begin
            checks++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got data=%h rd=%0d fault=%b", resp_data, resp_rd, resp_fault);
            end else begin
                e = exp_q.pop_front();
                if (resp_data !== e.data || resp_rd !== e.rd || resp_fault !== e.fault) begin
                    failures++;
                    $display("FAIL resp: got data=%h rd=%0d fault=%b expected data=%h rd=%0d fault=%b",
                             resp_data, resp_rd, resp_fault, e.data, e.rd, e.fault);
                end
            end
        end
    end

    // Drive one request until accepted; returns at posedge+1 of the accept edge (or one cycle later)
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input bit hold);
        resp_t e;
        int n;
        bit done;
        e = model(st, f3, a, wd, rd);
        exp_q.push_back(e);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1;
        n = 0;
        done = 0;
        while (!done && n < 50) begin
            @(negedge clock);
            n++;
            if (req_ready) begin
                @(posedge clock);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no handshake expected one within 50 cycles");
        end
        if (!hold) begin
            req_valid = 0;
            @(negedge clock);
            chk("resp_valid_after_accept", {31'h0, resp_valid}, {31'h0, e.fault});
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            if (rnd) resp_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        resp_ready = 1;
    endtask

    initial begin
        int w0;
        resp_t e;
        for (int i = 0; i < MB; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", {31'h0, req_ready}, 0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 0);
        chk("rst_mem_we", {31'h0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_size", {30'h0, mem_size}, 0);
        chk("rst_resp_data", resp_data, 0);
        @(posedge clock);
        #1;
        reset = 0;
        resp_ready = 1;
        @(negedge clock);
        chk("idle_req_ready", {31'h0, req_ready}, 1);
        @(posedge clock);
        #1;

        w0 = we_cycles;
        issue(1, SW, 4, 32'hDEADBEEF, 7, 0);
        drain();
        chk("sw_we_cycles", we_cycles - w0, 1);
        issue(0, LW, 4, 0, 3, 0);
        issue(0, LB, 4, 0, 4, 0);
        issue(0, LBU, 4, 0, 5, 0);
        issue(0, LH, 4, 0, 6, 0);
        issue(0, LHU, 6, 0, 8, 0);
        drain();

        w0 = we_cycles;
        issue(0, LW, 2, 0, 1, 0);
        issue(0, LW, 20, 0, 2, 0);
        issue(1, 3'b100, 8, 32'h55, 3, 0);
        drain();
        chk("fault_no_we", we_cycles - w0, 0);

        resp_ready = 0;
        w0 = we_cycles;
        issue(0, LW, 4, 0, 9, 0);
        e = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            req_store = 1; req_funct3 = SW; req_addr = 0; req_wdata = 32'h12345678;
            req_valid = (i == 1);
            @(negedge clock);
            chk("bp_resp_valid", {31'h0, resp_valid}, 1);
            chk("bp_resp_data", resp_data, e.data);
            chk("bp_resp_rd", {27'h0, resp_rd}, {27'h0, e.rd});
            chk("bp_req_ready", {31'h0, req_ready}, 0);
            @(posedge clock);
            #1;
        end
        req_valid = 0;
        resp_ready = 1;
        drain();
        repeat (5) @(posedge clock);
        #1;
        chk("bp_no_extra_we", we_cycles - w0, 0);

        resp_ready = 0;
        issue(0, LW, 4, 0, 11, 0);
        @(negedge clock);
        chk("rr_resp_valid", {31'h0, resp_valid}, 1);
        @(posedge clock);
        #1;
        reset = 1;
        @(posedge clock);
        #1;
        exp_q.delete();
        @(negedge clock);
        chk("rr_valid_dropped", {31'h0, resp_valid}, 0);
        chk("rr_ready_in_reset", {31'h0, req_ready}, 0);
        @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
        chk("rr_ready_after", {31'h0, req_ready}, 1);
        chk("rr_fault_cleared", {31'h0, resp_fault}, 0);
        @(posedge clock);
        #1;
        resp_ready = 1;
        issue(0, LW, 4, 0, 12, 0);
        drain();

        hs_cyc.delete();
        issue(0, LW, 4, 0, 13, 1);
        issue(0, LH, 6, 0, 14, 1);
        issue(0, LBU, 5, 0, 15, 1);
        req_valid = 0;
        drain();
        chk("b2b_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("b2b_gap1", hs_cyc[1] - hs_cyc[0], 3);
            chk("b2b_gap2", hs_cyc[2] - hs_cyc[1], 3);
        end

        rnd = 1;
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0 ? 32'hFFFFFFF0 + $urandom_range(0, 15) : $urandom_range(0, 24),
                  $urandom, 5'($urandom), 0);
            drain();
        end
        rnd = 0;
        chk("total_we_cycles", we_cycles, exp_we);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencing front end between the pipeline's memory stage and the byte-addressed, big-endian data memory. Accepts one load or store request per valid/ready handshake and decodes RV32I funct3 into the memory's size/sign-extend/write-enable controls. Checks alignment and range before any access. Returns a registered response (load data or fault) through a second valid/ready handshake, so the pipeline stalls cleanly on memory operations.

## Interface
- `MEM_BYTES`, default 21: number of implemented data-memory bytes; valid byte addresses are 0..MEM_BYTES-1.
- `clock`  in  1: sole clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_store`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I load/store funct3.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-justified.
- `req_rd`  in  5: load destination register.
- `mem_addr`  out  32: to data memory `addr`.
- `mem_data_in`  out  32: to data memory `data_in`.
- `mem_we`  out  1: to data memory `we`.
- `mem_size`  out  2: to data memory `size` (0 = byte, 1 = half, 3 = word; 2 is never driven).
- `mem_sign_extend`  out  1: to data memory `sign_extend`.
- `mem_data_out`  in  32: from data memory, combinational read data.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts response.
- `resp_data`  out  32: load result; 0 for stores and faults.
- `resp_rd`  out  5: latched `req_rd` for legal loads; 0 for stores and faults.
- `resp_fault`  out  1: illegal funct3, misaligned, or out-of-range access.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid` the block latches all request fields.
  - Legal, in-range request: go to ACCESS.
  - Faulting request: go straight to RESP with `resp_fault`=1. No ACCESS cycle, no write.
- Decode:
  - 000 = byte, signed.
  - 001 = half, signed.
  - 010 = word.
  - 100 = byte, unsigned; load only.
  - 101 = half, unsigned; load only.
  - Any other code, or 100/101 with `req_store`=1, is illegal and faults.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
- Range: addr + nbytes ≤ MEM_BYTES. Compute in 33 bits so that addr near 2^32 cannot wrap.
- ACCESS lasts exactly one cycle:
  - `mem_we` = `req_store`.
  - `mem_data_in` = latched wdata.
  - `mem_size` and `mem_sign_extend` come from decode.
  - For a load, `mem_data_out` is captured into `resp_data` at the closing posedge.
  - Next state is RESP.
- RESP: `resp_valid`=1, with all resp fields held stable until `resp_ready`=1, then go to IDLE.
- `req_ready`=0 in ACCESS and RESP. At most one request is outstanding.
- Outside ACCESS: `mem_we`=0; `mem_addr`, `mem_size` and `mem_sign_extend` hold their last latched values.
- Byte order: the data memory is big-endian, so `mem_addr` receives the lowest byte address and that byte is the MSB. No lane shifting is done here.

## Timing
- Reset values: state IDLE; `req_ready`=0 while `reset` is high. Zero on reset: `mem_we`, `mem_addr`, `mem_data_in`, `mem_size`, `mem_sign_extend`, `resp_valid`, `resp_data`, `resp_rd`, `resp_fault`.
- Legal request accepted at edge N:
  - ACCESS is cycle N..N+1.
  - The store commits at the data memory's negedge inside that cycle.
  - `resp_valid` rises after edge N+1.
  - Minimum occupancy is 3 cycles per request.
- Faulting request accepted at edge N: `resp_valid` rises after edge N; 2 cycles per request.
- Reset asserted during ACCESS: that cycle's store has already committed at the negedge. The reset edge returns the block to IDLE and discards the response.
- Reset asserted during RESP: the pending response is dropped and `resp_valid`=0 on the next cycle.
- `req_valid` while `req_ready`=0 is ignored. The requester must hold the request until the handshake.
- `resp_ready` asserted in the same cycle `resp_valid` rises completes the handshake at the next edge.

## Structure
- Shared package/header holds: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), memory size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=3), and the state encoding.
- One combinational sub-module, `lsu_decode`: maps funct3, store, addr and MEM_BYTES to size, sign_extend, nbytes and fault. The top level holds the FSM and registers.

## Test plan
- SW 0xDEADBEEF @4, then LW @4 → `resp_data`=0xDEADBEEF, `resp_fault`=0. The store's `resp_rd`=0; `mem_we` is high for exactly one cycle.
- After that store:
  - LB @4 → 0xFFFFFFDE.
  - LBU @4 → 0x000000DE.
  - LH @4 → 0xFFFFDEAD.
  - LHU @6 → 0x0000BEEF.
- Faults:
  - LW @2 (misaligned) → `resp_fault`=1, `resp_data`=0, no ACCESS cycle.
  - LW @20 with MEM_BYTES=21 (out of range) → fault.
  - SB with funct3=100 → fault, `mem_we` never high.
- Backpressure: hold `resp_ready`=0 for 4 cycles during RESP → `resp_valid`, `resp_data` and `resp_rd` stay stable and `req_ready`=0 throughout; a `req_valid` pulse in that window is not accepted.
- Reset in RESP after LW @4 → next cycle `resp_valid`=0 and `req_ready`=1 once reset is low; a subsequent LW @4 still returns 0xDEADBEEF.
- Back-to-back: `req_valid` held high with 3 legal loads and `resp_ready`=1 → responses appear 3 cycles apart, in order, with the correct `resp_rd` values.
